// File: rtl/glip_upscale_n.sv
// Width upscaler: packs FACTOR input words (first word in the low lane) into one
// registered output word; a flush emits a partial word tagged with its lane count.
module glip_upscale_n #(
  parameter int IN_SIZE = 8,
  parameter int FACTOR  = 2,
  parameter int CNT_W   = $clog2(FACTOR + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IN_SIZE-1:0]          in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        flush,
  output logic [IN_SIZE*FACTOR-1:0]   out_data,
  output logic [CNT_W-1:0]            out_count,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int FILL_W = $clog2(FACTOR);
  localparam int OUT_W  = IN_SIZE * FACTOR;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FACTOR - 1);

  logic [(FACTOR-1)*IN_SIZE-1:0] acc_q, acc_d;
  logic [FILL_W-1:0]             fill_q, fill_d;
  logic [OUT_W-1:0]              out_data_q, out_data_d;
  logic [CNT_W-1:0]              out_count_q, out_count_d;
  logic                          out_valid_q, out_valid_d;
  logic                          flush_pend_q, flush_pend_d;

  logic             ld_ok, acc_open, in_xfer, complete;
  logic             flush_req, service, emit, acc_we;
  logic [CNT_W-1:0] n_words;
  logic [OUT_W-1:0] packed_word;

  assign ld_ok     = !out_valid_q || out_ready;
  assign acc_open  = (fill_q != FILL_MAX);
  assign in_ready  = acc_open || ld_ok;
  assign in_xfer   = in_valid && in_ready;
  assign complete  = in_xfer && !acc_open;
  assign flush_req = flush_pend_q || flush;
  // A completing word takes priority; any flush stays pending behind it.
  assign service   = flush_req && ld_ok && !complete;
  assign n_words   = CNT_W'(fill_q) + CNT_W'(in_xfer);
  assign emit      = complete || (service && (n_words != '0));
  assign acc_we    = in_xfer && !complete && !service;

  // Lanes below fill come from acc, lane fill takes the same-cycle input, the rest are zero.
  // With fill at FACTOR-1 this yields the full word, so flush and completion share one path.
  genvar gi;
  generate
    for (gi = 0; gi < FACTOR; gi++) begin : g_lane
      logic [IN_SIZE-1:0] held;
      if (gi < FACTOR - 1) begin : g_acc
        assign held = acc_q[gi*IN_SIZE +: IN_SIZE];
        assign acc_d[gi*IN_SIZE +: IN_SIZE] =
          (acc_we && (fill_q == FILL_W'(gi))) ? in_data : held;
      end else begin : g_top
        assign held = '0;
      end
      assign packed_word[gi*IN_SIZE +: IN_SIZE] =
        (fill_q > FILL_W'(gi))                 ? held    :
        (in_xfer && (fill_q == FILL_W'(gi)))   ? in_data : '0;
    end
  endgenerate

  always_comb begin
    fill_d       = fill_q;
    flush_pend_d = flush_req;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    out_valid_d  = out_valid_q && !out_ready;
    if (service) begin
      flush_pend_d = 1'b0;
    end
    if (emit) begin
      out_data_d  = packed_word;
      out_count_d = n_words;
      out_valid_d = 1'b1;
    end
    if (emit || service) begin
      fill_d = '0;
    end else if (acc_we) begin
      fill_d = fill_q + FILL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_q       <= '0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      fill_q       <= fill_d;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // Accumulator contents are qualified by fill, so they need no reset.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/glip_upscale_n.md
Name: glip_upscale_n

Overview:
Parametrised FIFO-interface width upscaler. Packs FACTOR consecutive IN_SIZE-bit input words into one IN_SIZE*FACTOR-bit output word, with the first word in the lowest bits.
- Registered output stage, so the accumulator keeps filling while the sink stalls.
- Flush request emits a partially filled word, tagged with its valid-word count.
- Sits between the GLIP logic-side FIFOs and wider transport/backend data paths.

Parameters:
- IN_SIZE, 8: input word width in bits, >=1.
- FACTOR, 2: number of input words per output word, >=2.
- CNT_W, $clog2(FACTOR+1): width of out_count. Derived; not to be overridden.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, release is synchronous to clk.
- in_data  input  IN_SIZE  input word.
- in_valid  input  1  input word valid.
- in_ready  output  1  block accepts in_data this cycle.
- flush  input  1  one-cycle request to emit any partially accumulated data.
- out_data  output  IN_SIZE*FACTOR  packed word; lane k = bits [k*IN_SIZE +: IN_SIZE].
- out_count  output  CNT_W  number of valid lanes in out_data, 1..FACTOR.
- out_valid  output  1  out_data/out_count valid.
- out_ready  input  1  sink accepts the output word.

Behaviour:
- Transfer rules: an input transfer happens when in_valid & in_ready; an output transfer when out_valid & out_ready.
- Internal state:
  - acc: FACTOR-1 lanes.
  - fill: 0..FACTOR-1 words currently held in acc.
  - out register: data, count, valid.
  - flush_pend flag.
- Reset (rst low, asynchronous): fill=0, flush_pend=0, out_valid=0, out_data=0, out_count=0, in_ready follows the combinational rule below.
- Output register is loadable (ld_ok) when !out_valid | out_ready.
- in_ready = (fill < FACTOR-1) | ld_ok. It is combinational and does not depend on in_valid.
- Input transfer with fill < FACTOR-1 and no flush service: in_data is written to acc lane fill, and fill increments.
- Input transfer with fill == FACTOR-1 (completing word):
  - out_data <= {in_data, acc}, out_count <= FACTOR, out_valid <= 1, fill <= 0.
  - Latency is 1 cycle: out_valid rises in the cycle after the last input word is accepted.
- flush=1 sets flush_pend. It is cleared only when serviced. Multiple flush pulses before service collapse into one.
- Flush service happens when (flush_pend | flush) & ld_ok, with no completing input transfer in that cycle.
  - Let n = fill + (input transfer ? 1 : 0). The same-cycle input word is included as lane fill.
  - n>0: out_data <= valid lanes 0..n-1, lanes n..FACTOR-1 forced to 0; out_count <= n; out_valid <= 1; fill <= 0; flush_pend <= 0.
  - n==0: flush_pend <= 0, no output is produced.
- Flush with a completing input in the same cycle: the full word is emitted normally (count FACTOR). flush_pend stays set and is serviced on a later cycle; since fill is then 0, it clears with no output unless new data arrives first.
- Flush while the output is stalled (out_valid & !out_ready): service is deferred. Inputs still accumulate up to FACTOR-1 words. in_ready drops when fill == FACTOR-1 and the output is stalled.
- While out_valid=1 and out_ready=0: out_data, out_count and out_valid hold stable.
- Output transfer with no new load in the same cycle: out_valid <= 0. The out_data value is don't-care after that and need not be cleared.
- Back-to-back throughput: with out_ready held at 1, one output per FACTOR input transfers and no bubbles on the input side.
- Reset asserted mid-accumulation or mid-stall: partial data is discarded and the pending output is dropped.

Test Plan:
All scenarios use IN_SIZE=8, FACTOR=4 unless noted.
1. Stream 0x11,0x22,0x33,0x44 with out_ready=1 -> out_data=0x44332211, out_count=4, out_valid 1 cycle after 0x44 is accepted; in_ready stays 1 throughout.
2. Continuous stream 0x00..0x0F with out_ready=1 -> four outputs: 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; no in_ready deassertion.
3. Send 0xA1,0xB2 then pulse flush -> next cycle out_data=0x0000B2A1, out_count=2; a subsequent 4-word stream packs from lane 0.
4. Hold out_ready=0 after one full word, then send 3 more words plus a 4th -> in_ready=0 while the 4th is presented; the first word is held stable. Raise out_ready -> first word transfers, 4th is accepted the same cycle, second word appears next cycle.
5. Flush with fill=0 and in_valid=0 -> no out_valid pulse. Flush in the same cycle as a 3rd word 0xC3 (after 0xC1,0xC2) -> out_data=0x00C3C2C1, out_count=3.
6. Assert rst low mid-accumulation (fill=2) while out_valid=1 and stalled -> out_valid=0, out_count=0 immediately without waiting for a clock edge. After release, 0x01..0x04 -> 0x04030201. Repeat scenario 1 with IN_SIZE=16, FACTOR=3.
